// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle controller: FSM state
// enum, RV32 opcode constants and the datapath select encodings.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    EXEC_I = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JAL    = 4'd10,
    HALT   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory stall watchdog: counts consecutive cycles in which a request is
// outstanding without mem_ready and flags expiry on the MEM_TIMEOUT-th one.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic waiting,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt;

  // Consecutive stall counter; any state change or served request restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !waiting) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expire = waiting && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control unit (load/store, R/I ALU, beq/bne, jal).
// Optional build macro PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       fault,
  output logic [3:0] state_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t state, next;
  logic   mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;
  logic   fault_set;
  logic   waiting, expire, state_chg;

  // Stall is derived from the state alone so the timer never feeds back
  // combinationally into itself through the next-state logic.
  assign waiting   = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
  assign state_chg = (next != state);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_chg),
    .waiting(waiting),
    .expire (expire)
  );

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= next;
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (fault_set) begin
      fault <= 1'b1;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next       = state;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    fault_set  = 1'b0;
    case (state)
      FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          next    = DECODE;
        end else if (expire) begin
          next      = HALT;
          fault_set = 1'b1;
        end
      end
      DECODE: begin
        // Branch/jump target precomputed into the ALU out register.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: next = MEMADR;
          OP_RTYPE:          next = EXEC_R;
          OP_ITYPE:          next = EXEC_I;
          OP_BRANCH:         next = BRANCH;
          OP_JAL:            next = JAL;
          default: begin
            next      = HALT;
            fault_set = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        next      = (opcode == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          next = MEMWB;
        end else if (expire) begin
          next      = HALT;
          fault_set = 1'b1;
        end
      end
      MEMWB: begin
        reg_we_c   = 1'b1;
        result_src = RES_MEM;
        next       = FETCH;
      end
      MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          next = FETCH;
        end else if (expire) begin
          next      = HALT;
          fault_set = 1'b1;
        end
      end
      EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        next      = ALUWB;
      end
      EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        next      = ALUWB;
      end
      ALUWB: begin
        reg_we_c   = 1'b1;
        result_src = RES_ALUOUT;
        next       = FETCH;
      end
      BRANCH: begin
        // Target from DECODE sits in the ALU out register; the ALU compares.
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        next       = FETCH;
        case (funct3)
          F3_BEQ:  pc_we_c = alu_zero;
          F3_BNE:  pc_we_c = !alu_zero;
          default: fault_set = 1'b1;
        endcase
      end
      JAL: begin
        // Jump target goes to PC while the ALU forms the link value oldPC+4.
        pc_we_c    = 1'b1;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        next       = ALUWB;
      end
      HALT: begin
        next = HALT;
      end
      default: begin
        next      = HALT;
        fault_set = 1'b1;
      end
    endcase
  end

  // Reset asynchronously kills every enable, even mid-access.
  assign mem_req = mem_req_c & rst_n;
  assign mem_we  = mem_we_c  & rst_n;
  assign ir_we   = ir_we_c   & rst_n;
  assign pc_we   = pc_we_c   & rst_n;
  assign reg_we  = reg_we_c  & rst_n;
  assign state_o = state;

`ifdef PERF_CNT_EN
  // Free-running cycle and retired-instruction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != HALT) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if ((next == FETCH) && (state != FETCH)) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of cycles to wait for mem_ready before faulting (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 7, instruction register bits [6:0].
REQ-005 SHALL have port funct3, input, 3, instruction register bits [14:12].
REQ-006 SHALL have port alu_zero, input, 1, ALU result-equals-zero flag.
REQ-007 SHALL have port mem_ready, input, 1, memory completes the current access.
REQ-008 SHALL have ports mem_req (output, 1) and mem_we (output, 1), the memory access request and write enable.
REQ-009 SHALL have ports ir_we, pc_we and reg_we (each output, 1), the register write enables.
REQ-010 SHALL have port adr_src, output, 1: 0 = PC, 1 = ALU result.
REQ-011 SHALL have ports alu_src_a and alu_src_b (each output, 2).
- alu_src_a: 00 PC, 01 oldPC, 10 rs1.
- alu_src_b: 00 rs2, 01 imm, 10 constant 4.
REQ-012 SHALL have port alu_op, output, 2: 00 add, 01 sub, 10 decode by funct.
REQ-013 SHALL have port result_src, output, 2: 00 ALU out register, 01 memory data, 10 ALU result.
REQ-014 SHALL have ports fault (output, 1), sticky error, and state_o (output, 4), the current state for debug.

Function
REQ-015 SHALL implement these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, HALT.
REQ-016 SHALL in FETCH assert mem_req with adr_src=0, and hold it until mem_ready; in the mem_ready cycle it SHALL pulse ir_we and pc_we (PC+4 via alu_src_a=00, alu_src_b=10, result_src=10), then go to DECODE.
REQ-017 SHALL in DECODE compute oldPC+imm (alu_src_a=01, alu_src_b=01), then branch on opcode.
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- 1101111 -> JAL
- anything else -> HALT with fault=1
REQ-018 SHALL in MEMADR compute rs1+imm, then go to MEMRD for a load or MEMWR for a store.
REQ-019 SHALL in MEMRD and MEMWR hold mem_req=1 and adr_src=1, with mem_we=1 in MEMWR only, until mem_ready.
- MEMRD -> MEMWB, which writes reg_we=1 with result_src=01, then -> FETCH.
- MEMWR -> FETCH.
REQ-020 SHALL in EXEC_R (rs1 op rs2, alu_op=10) and EXEC_I (rs1 op imm, alu_op=10) go next to ALUWB, which asserts reg_we=1 with result_src=00, then -> FETCH.
REQ-021 SHALL in BRANCH subtract rs1-rs2 and assert pc_we with result_src=00 when (funct3=000 and alu_zero) or (funct3=001 and !alu_zero); other funct3 values SHALL fault; the next state SHALL be FETCH.
REQ-022 SHALL in JAL assert pc_we with result_src=00, compute oldPC+4, then go to ALUWB.
REQ-023 SHALL give the following instruction latencies, counting from the FETCH cycle in which mem_ready is high:
- load: 5
- store: 4
- R/I: 4
- branch: 3
- jal: 4
REQ-024 SHALL count consecutive wait cycles while mem_req=1 and !mem_ready; when the count reaches MEM_TIMEOUT the block SHALL go to HALT with fault=1; the counter SHALL clear on every state change.
REQ-025 SHALL treat HALT as absorbing: all enables 0 and mem_req 0 until reset.
REQ-026 SHALL hold every enable at 0 in any state that does not name it.

Reset
REQ-027 SHALL on rst_n=0 immediately force state FETCH, the wait counter to 0 and fault to 0, and deassert all enables and mem_req, including when reset arrives in the middle of an access.
REQ-028 SHALL after rst_n rises issue its first mem_req on the first clk edge.

Configuration
REQ-029 SHALL, with PERF_CNT_EN defined, add outputs cycle_cnt (32) and instret_cnt (32).
- cycle_cnt increments every non-HALT cycle.
- instret_cnt increments on each transition into FETCH from a non-FETCH state.
- Both reset to 0 and wrap modulo 2^32.
REQ-030 SHALL, with PERF_CNT_EN undefined, have neither port nor the counter logic.

Structure
REQ-031 SHALL place the state enum, opcode constants and the alu_src, alu_op and result_src encodings in the package multicycle_pkg.
REQ-032 SHALL implement the wait counter and timeout compare in the sub-module mem_wait_timer.

Verification
REQ-033 SHALL cover: R-type opcode 0110011 with mem_ready tied 1 -> reg_we pulse exactly 4 cycles after the first FETCH.
REQ-034 SHALL cover: load with mem_ready low for 3 extra cycles in MEMRD -> mem_req held 4 cycles, then MEMWB with result_src=01.
REQ-035 SHALL cover: beq with alu_zero=1 -> pc_we pulse in BRANCH; with alu_zero=0 -> no pc_we.
REQ-036 SHALL cover: MEM_TIMEOUT=4 with mem_ready held 0 -> HALT and fault=1 after 4 wait cycles; outputs quiescent thereafter.
REQ-037 SHALL cover: opcode 0000000 -> HALT/fault after DECODE; rst_n pulse during MEMWR -> mem_req drops asynchronously and restart is in FETCH.
REQ-038 SHALL cover: with PERF_CNT_EN defined, three back-to-back R-type instructions -> instret_cnt=3 and cycle_cnt=12.
